// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   fetch_state_t     : states of the instruction-fetch FSM
//   ISSUE_SLOT_CYCLES : cycles an issue slot stays open for decode (ISSUE..HOLD2)
package cpu_pkg;

  typedef enum logic [2:0] {
    F_IDLE,
    F_ADDR,
    F_DATA,
    F_ISSUE,
    F_HOLD1,
    F_HOLD2
  } fetch_state_t;

  localparam int unsigned ISSUE_SLOT_CYCLES = 3;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage feeding inst_decode.
// Owns the PC, reads an external synchronous instruction BRAM and presents
// inst/pc/pc1/distinct in a 3-cycle issue slot opened by a one-cycle
// inst_enable pulse. Redirects from execute either abort an in-flight fetch
// or are held pending until the open slot closes; each accepted redirect
// toggles the epoch bit, which is reported as distinct on later instructions.
// Ports:
//   CLK, reset       clock; synchronous active-high reset
//   start            level; fetch runs while high, parks in IDLE when low
//   stall            downstream busy; extends the HOLD2 cycle of a slot
//   redirect         one-cycle pulse with target redirect_pc
//   imem_addr        BRAM read address (the current fetch PC)
//   imem_rdata       BRAM data, one cycle after the address is sampled
//   inst, pc, pc1    issued instruction, its address and address+1 (wrapping)
//   distinct         epoch bit of inst
//   inst_enable      one-cycle pulse opening an issue slot
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned                INST_MEM_WIDTH = 2,
  parameter logic [INST_MEM_WIDTH-1:0]  RESET_PC       = '0
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [INST_MEM_WIDTH-1:0] redirect_pc,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  input  logic [31:0]               imem_rdata,
  output logic [31:0]               inst,
  output logic [INST_MEM_WIDTH-1:0] pc,
  output logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      distinct,
  output logic                      inst_enable
);

  fetch_state_t                state_q, state_d;
  logic [INST_MEM_WIDTH-1:0]   pc_reg_q, pc_reg_d;
  logic [INST_MEM_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
  logic                        redirect_pend_q, redirect_pend_d;
  logic                        epoch_q, epoch_d;
  logic [31:0]                 inst_q, inst_d;
  logic [INST_MEM_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_MEM_WIDTH-1:0]   pc1_q, pc1_d;
  logic                        distinct_q, distinct_d;
  logic [INST_MEM_WIDTH-1:0]   pc_inc;

  // Address arithmetic wraps modulo 2^INST_MEM_WIDTH by truncation.
  assign pc_inc = pc_reg_q + INST_MEM_WIDTH'(1);

  always_comb begin
    state_d         = state_q;
    pc_reg_d        = pc_reg_q;
    redirect_pc_d   = redirect_pc_q;
    redirect_pend_d = redirect_pend_q;
    epoch_d         = epoch_q;
    inst_d          = inst_q;
    pc_d            = pc_q;
    pc1_d           = pc1_q;
    distinct_d      = distinct_q;

    unique case (state_q)
      F_IDLE: begin
        if (redirect) begin
          pc_reg_d = redirect_pc;
          epoch_d  = ~epoch_q;
        end else if (start) begin
          state_d = F_ADDR;
        end
      end
      F_ADDR, F_DATA: begin
        // No slot is open yet, so a redirect simply restarts the fetch.
        if (redirect) begin
          pc_reg_d = redirect_pc;
          epoch_d  = ~epoch_q;
          state_d  = F_ADDR;
        end else if (state_q == F_DATA) begin
          inst_d     = imem_rdata;
          pc_d       = pc_reg_q;
          pc1_d      = pc_inc;
          distinct_d = epoch_q;
          state_d    = F_ISSUE;
        end else begin
          state_d = F_DATA;
        end
      end
      F_ISSUE, F_HOLD1: begin
        if (redirect) begin
          redirect_pend_d = 1'b1;
          redirect_pc_d   = redirect_pc;
        end
        state_d = (state_q == F_ISSUE) ? F_HOLD1 : F_HOLD2;
      end
      F_HOLD2: begin
        if (stall) begin
          if (redirect) begin
            redirect_pend_d = 1'b1;
            redirect_pc_d   = redirect_pc;
          end
        end else begin
          // A redirect arriving on the exit cycle bypasses the pending register;
          // any number of redirects within one slot toggle the epoch once.
          if (redirect) begin
            pc_reg_d = redirect_pc;
            epoch_d  = ~epoch_q;
          end else if (redirect_pend_q) begin
            pc_reg_d = redirect_pc_q;
            epoch_d  = ~epoch_q;
          end else begin
            pc_reg_d = pc_inc;
          end
          redirect_pend_d = 1'b0;
          state_d         = start ? F_ADDR : F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q         <= F_IDLE;
      pc_reg_q        <= RESET_PC;
      redirect_pc_q   <= '0;
      redirect_pend_q <= 1'b0;
      epoch_q         <= 1'b0;
      inst_q          <= '0;
      pc_q            <= '0;
      pc1_q           <= '0;
      distinct_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_reg_q        <= pc_reg_d;
      redirect_pc_q   <= redirect_pc_d;
      redirect_pend_q <= redirect_pend_d;
      epoch_q         <= epoch_d;
      inst_q          <= inst_d;
      pc_q            <= pc_d;
      pc1_q           <= pc1_d;
      distinct_q      <= distinct_d;
    end
  end

  assign imem_addr   = pc_reg_q;
  assign inst        = inst_q;
  assign pc          = pc_q;
  assign pc1         = pc1_q;
  assign distinct    = distinct_q;
  assign inst_enable = (state_q == F_ISSUE);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam int W = 2;

  logic          CLK = 1'b0;
  logic          reset, start, stall, redirect;
  logic [W-1:0]  redirect_pc, imem_addr, pc, pc1;
  logic [31:0]   imem_rdata, inst;
  logic          distinct, inst_enable;
  logic [31:0]   mem [4];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Synchronous instruction BRAM: data appears one cycle after the address.
  always @(posedge CLK) imem_rdata <= mem[imem_addr];

  inst_fetch #(.INST_MEM_WIDTH(W), .RESET_PC(2'd0)) dut (
    .CLK(CLK), .reset(reset), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc), .pc1(pc1), .distinct(distinct),
    .inst_enable(inst_enable)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit en, input int epc, input int epc1,
                         input logic [31:0] einst, input int ed);
    chk({tag, " inst_enable"}, 32'(inst_enable), 32'(en));
    chk({tag, " pc"},          32'(pc),          32'(epc));
    chk({tag, " pc1"},         32'(pc1),         32'(epc1));
    chk({tag, " inst"},        inst,             einst);
    chk({tag, " distinct"},    32'(distinct),    32'(ed));
  endtask

  // Directed timeline: one record per cycle that carries an input event or an issue.
  typedef struct {
    int cyc;
    bit stl;
    bit red;
    int rpc;
    bit en;
    int epc;
    bit edist;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int c, bit s, bit r, int rp, bit e, int p, bit d);
    vec_t v;
    v.cyc = c; v.stl = s; v.red = r; v.rpc = rp; v.en = e; v.epc = p; v.edist = d;
    return v;
  endfunction

  // Reference model: m_age counts cycles since the fetch address was presented
  // (-1 when parked); a slot is issued at age 2 and may close from age 4 on.
  int m_age, m_pc, m_ep, m_pend, m_tgt, o_pc, o_pc1, o_d;
  logic [31:0] o_inst;

  task automatic model_step();
    if (reset) begin
      m_age = -1; m_pc = 0; m_ep = 0; m_pend = 0; m_tgt = 0;
      o_pc = 0; o_pc1 = 0; o_d = 0; o_inst = '0;
      return;
    end
    if (m_age < 0) begin
      if (redirect) begin m_pc = int'(redirect_pc); m_ep ^= 1; end
      else if (start) m_age = 0;
    end else if (m_age <= 1) begin
      if (redirect) begin
        m_pc = int'(redirect_pc); m_ep ^= 1; m_age = 0;
      end else if (m_age == 1) begin
        o_inst = mem[m_pc]; o_pc = m_pc; o_pc1 = (m_pc + 1) % 4; o_d = m_ep; m_age = 2;
      end else m_age = 1;
    end else if (m_age < 4 || stall) begin
      if (redirect) begin m_pend = 1; m_tgt = int'(redirect_pc); end
      if (m_age < 4) m_age++;
    end else begin
      if (redirect || m_pend != 0) begin
        m_pc = redirect ? int'(redirect_pc) : m_tgt;
        m_ep ^= 1;
      end else m_pc = (m_pc + 1) % 4;
      m_pend = 0;
      m_age = start ? 0 : -1;
    end
  endtask

  initial begin
    int hp, hp1, hd;
    logic [31:0] hi;
    bit en;

    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_00A0 + 32'(i);

    tick(); tick();
    chk_out("reset", 1'b0, 0, 0, 32'h0, 0);
    chk("reset imem_addr", 32'(imem_addr), 32'h0);

    // Sequential fetch with wrap, pending redirect, aborting redirect, stall.
    tbl.push_back(mk( 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk( 8, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(13, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(18, 0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(23, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(25, 0, 1, 2, 0, 0, 0));   // redirect sampled in HOLD1
    tbl.push_back(mk(28, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(33, 0, 1, 1, 0, 0, 0));   // redirect sampled in DATA of pc=3
    tbl.push_back(mk(35, 0, 0, 0, 1, 1, 0));
    for (int c = 38; c <= 41; c++) tbl.push_back(mk(c, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(44, 0, 0, 0, 1, 2, 0));

    reset = 1'b0; start = 1'b1;
    hp = 0; hp1 = 0; hd = 0; hi = '0;
    for (int c = 1; c <= 44; c++) begin
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0; en = 1'b0;
      foreach (tbl[i]) if (tbl[i].cyc == c) begin
        stall = tbl[i].stl; redirect = tbl[i].red; redirect_pc = W'(tbl[i].rpc);
        if (tbl[i].en) begin
          en = 1'b1; hp = tbl[i].epc; hp1 = (hp + 1) % 4; hd = int'(tbl[i].edist); hi = mem[hp];
        end
      end
      tick();
      chk_out($sformatf("table c%0d", c), en, hp, hp1, hi, hd);
    end
    stall = 1'b0; redirect = 1'b0;

    // Reset while in HOLD1 of the pc=2 slot.
    tick();
    reset = 1'b1;
    tick();
    chk_out("midslot reset", 1'b0, 0, 0, 32'h0, 0);
    chk("midslot reset imem_addr", 32'(imem_addr), 32'h0);
    reset = 1'b0;
    tick(); chk("restart c1 en", 32'(inst_enable), 32'h0);
    tick(); chk("restart c2 en", 32'(inst_enable), 32'h0);
    tick(); chk_out("restart issue", 1'b1, 0, 1, mem[0], 0);

    // Two redirects in one slot: newest target wins, epoch toggles once.
    redirect = 1'b1; redirect_pc = 2'd3; tick();
    chk_out("dual red hold1", 1'b0, 0, 1, mem[0], 0);
    redirect_pc = 2'd2; tick();
    redirect = 1'b0;
    chk_out("dual red hold2", 1'b0, 0, 1, mem[0], 0);
    tick(); tick();
    chk("dual red data en", 32'(inst_enable), 32'h0);
    tick(); chk_out("dual red issue", 1'b1, 2, 3, mem[2], 1);

    // Redirect coincident with the HOLD2 exit is taken directly.
    tick(); tick();
    redirect = 1'b1; redirect_pc = 2'd1; tick();
    redirect = 1'b0;
    tick(); tick();
    chk_out("exit red issue", 1'b1, 1, 2, mem[1], 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick(); model_step();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 9) != 0);
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = W'($urandom_range(0, 3));
      tick();
      model_step();
      chk_out("random", (m_age == 2), o_pc, o_pc1, o_inst, o_d);
      if (m_age == 0) chk("random imem_addr", 32'(imem_addr), 32'(m_pc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
